// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cam_pkg
//  Description : Shared constants and FSM state encoding for the camera
//                frame-capture sequencer (QQVGA geometry, DP-RAM sizing).
//  Revision    : 1.0  initial release
// ============================================================================
package cam_pkg;

  localparam int AW           = 15;   // DP_RAM address width
  localparam int CAM_SCREEN_X = 160;  // pixels per line
  localparam int CAM_SCREEN_Y = 120;  // lines per frame
  localparam int IMA_SIZ      = CAM_SCREEN_X * CAM_SCREEN_Y;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cam_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : cam_edge_det
//  Description : Registered edge detector. Keeps a one-cycle delayed copy of
//                i_sig and produces a one-cycle pulse on the selected edge.
//  Ports       : clk, rst      clock / synchronous active-high reset
//                i_sig         level input (synchronous to clk)
//                o_pulse       high for one cycle on the selected edge
//  Parameters  : FALL          0 = rising-edge pulse, 1 = falling-edge pulse
//  Revision    : 1.0  initial release
// ============================================================================
module cam_edge_det #(
  parameter bit FALL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_pulse
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) r_q <= 1'b0;
    else     r_q <= i_sig;
  end

  generate
    if (FALL) begin : g_fall
      assign o_pulse = r_q & ~i_sig;
    end else begin : g_rise
      assign o_pulse = i_sig & ~r_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/cam_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cam_capture_ctrl
//  Description : Frame-capture sequencer between cam_read and buffer_ram_dp.
//                Gates the pixel write-enable so only whole frames reach the
//                buffer, supports single-shot / continuous capture and checks
//                line and pixel counts against the expected geometry.
//  Ports       : clk, rst        pixel clock / synchronous active-high reset
//                start, stop     capture request / abort-finish request
//                continuous      re-arm after each frame when high
//                CAM_vsync/href  camera sync signals
//                regW_in,addr_in pixel strobe and address from cam_read
//                DP_RAM_regW     gated write-enable to the frame buffer
//                capt_busy       high while armed or capturing
//                frame_done      one-cycle pulse per completed frame
//                line_err        sticky geometry error, cleared on start
//                frame_cnt       completed-frame counter
//  Config      : CAPT_STATS_EN   defined   -> frame_cnt counts frames
//                                undefined -> frame_cnt tied to zero
//  Revision    : 1.0  initial release
// ============================================================================
module cam_capture_ctrl #(
  parameter int AW           = cam_pkg::AW,
  parameter int CAM_SCREEN_X = cam_pkg::CAM_SCREEN_X,
  parameter int CAM_SCREEN_Y = cam_pkg::CAM_SCREEN_Y
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          continuous,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic          regW_in,
  input  logic [AW-1:0] addr_in,
  output logic          DP_RAM_regW,
  output logic          capt_busy,
  output logic          frame_done,
  output logic          line_err,
  output logic [15:0]   frame_cnt
);
  import cam_pkg::state_t;
  import cam_pkg::ST_IDLE;
  import cam_pkg::ST_ARM;
  import cam_pkg::ST_CAPT;
  import cam_pkg::ST_DONE;

  localparam logic [AW:0] c_ima_siz = (AW+1)'(CAM_SCREEN_X * CAM_SCREEN_Y);
  localparam logic [8:0]  c_px_line = 9'(CAM_SCREEN_X);
  localparam logic [6:0]  c_lines   = 7'(CAM_SCREEN_Y);

  state_t     r_state, w_state_nxt;
  logic       r_stop_pend;
  logic       r_line_err;
  logic [7:0] r_px_cnt;
  logic [6:0] r_line_cnt;

  logic       w_vs_rise, w_vs_fall, w_hr_fall;
  logic       w_in_capt, w_addr_ok, w_wr, w_start_ok;
  logic [8:0] w_px_line;

  cam_edge_det #(.FALL(1'b0)) u_vs_rise (.clk(clk), .rst(rst), .i_sig(CAM_vsync), .o_pulse(w_vs_rise));
  cam_edge_det #(.FALL(1'b1)) u_vs_fall (.clk(clk), .rst(rst), .i_sig(CAM_vsync), .o_pulse(w_vs_fall));
  cam_edge_det #(.FALL(1'b1)) u_hr_fall (.clk(clk), .rst(rst), .i_sig(CAM_href),  .o_pulse(w_hr_fall));

  assign w_in_capt  = (r_state == ST_CAPT);
  assign w_addr_ok  = ({1'b0, addr_in} < c_ima_siz);
  assign w_wr       = regW_in & w_in_capt & w_addr_ok;
  assign w_start_ok = (r_state == ST_IDLE) & start & ~stop;
  // Pixel total of the line including a write landing on the href-fall cycle.
  assign w_px_line  = {1'b0, r_px_cnt} + {8'd0, w_wr};

  assign DP_RAM_regW = w_wr;
  assign capt_busy   = (r_state == ST_ARM) | (r_state == ST_CAPT);
  assign frame_done  = (r_state == ST_DONE);
  assign line_err    = r_line_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start && !stop) w_state_nxt = ST_ARM;
      ST_ARM: begin
        if (stop)           w_state_nxt = ST_IDLE;
        else if (w_vs_fall) w_state_nxt = ST_CAPT;
      end
      // A frame in progress always completes; stop only prevents re-arming.
      ST_CAPT: if (w_vs_rise || (r_line_cnt == c_lines)) w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (continuous && !r_stop_pend && !stop) w_state_nxt = ST_ARM;
        else                                     w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_stop_pend <= 1'b0;
      r_line_err  <= 1'b0;
      r_px_cnt    <= 8'd0;
      r_line_cnt  <= 7'd0;
    end else begin
      r_state <= w_state_nxt;

      if (w_state_nxt == ST_IDLE)  r_stop_pend <= 1'b0;
      else if (stop && w_in_capt)  r_stop_pend <= 1'b1;

      if (w_start_ok) begin
        r_line_err <= 1'b0;
      end else if (w_in_capt) begin
        if ((regW_in && !w_addr_ok) ||
            (w_hr_fall && (w_px_line != c_px_line)) ||
            (w_vs_rise && (r_line_cnt < c_lines)))
          r_line_err <= 1'b1;
      end

      if ((r_state == ST_ARM) && w_vs_fall && !stop) begin
        r_px_cnt   <= 8'd0;
        r_line_cnt <= 7'd0;
      end else if (w_in_capt) begin
        if (w_hr_fall) begin
          r_px_cnt   <= 8'd0;
          r_line_cnt <= r_line_cnt + 7'd1;
        end else if (w_wr) begin
          r_px_cnt   <= r_px_cnt + 8'd1;
        end
      end
    end
  end

`ifdef CAPT_STATS_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (rst)                     r_frame_cnt <= 16'd0;
    else if (r_state == ST_DONE) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cam_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cam_capture_ctrl
//  Description : Self-checking bench for cam_capture_ctrl. A full-size
//                (160x120) instance and a reduced (16x8) instance share the
//                same camera stimulus; each scenario checks the relevant one.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cam_capture_ctrl;

  localparam int BX = 160, BY = 120, BIMA = BX * BY;
  localparam int SX = 16,  SY = 8,   SIMA = SX * SY;
`ifdef CAPT_STATS_EN
  localparam int FCNT3 = 3;
`else
  localparam int FCNT3 = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stop, continuous, vsync, href, regw;
  logic [14:0] addr;
  logic        b_regw, b_busy, b_done, b_err;
  logic        s_regw, s_busy, s_done, s_err;
  logic [15:0] b_fcnt, s_fcnt;

  cam_capture_ctrl #(.AW(15), .CAM_SCREEN_X(BX), .CAM_SCREEN_Y(BY)) u_big (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .CAM_vsync(vsync), .CAM_href(href), .regW_in(regw), .addr_in(addr),
    .DP_RAM_regW(b_regw), .capt_busy(b_busy), .frame_done(b_done),
    .line_err(b_err), .frame_cnt(b_fcnt));

  cam_capture_ctrl #(.AW(15), .CAM_SCREEN_X(SX), .CAM_SCREEN_Y(SY)) u_small (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .CAM_vsync(vsync), .CAM_href(href), .regW_in(regw), .addr_in(addr),
    .DP_RAM_regW(s_regw), .capt_busy(s_busy), .frame_done(s_done),
    .line_err(s_err), .frame_cnt(s_fcnt));

  int total = 0, passed = 0;
  int wr_b = 0, wr_s = 0, fd_b = 0, fd_s = 0, gap_s = 0;
  bit mon_clr = 1'b0;
  int err_line [0:127];
  int snap_rst;

  // Pulse counters, sampled mid-cycle while inputs and state are stable.
  always @(negedge clk) begin
    if (mon_clr) begin
      wr_b = 0; wr_s = 0; fd_b = 0; fd_s = 0; gap_s = 0;
    end else begin
      wr_b  += int'(b_regw);
      wr_s  += int'(s_regw);
      fd_b  += int'(b_done);
      fd_s  += int'(s_done);
      if (!s_busy && !s_done) gap_s++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1; @(negedge clk); #1; mon_clr = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; regw = 1'b0; href = 1'b0; vsync = 1'b1; addr = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0; tick();
  endtask

  // Drives one vsync-framed frame and returns what a capturing controller
  // must produce: writes = pixels with an in-range address, error = any line
  // whose length differs from x, any out-of-range address, or too few lines.
  task automatic send_frame(input int x, input int y, input int nlines, input int ima,
                            input int short_line, input int bad_line, input int start_line,
                            input int stop_line, input int rst_line, input bit rand_len,
                            output int exp_wr, output bit exp_err);
    int acnt, n, a;
    acnt = 0; exp_wr = 0; exp_err = 1'b0;
    vsync = 1'b1; tick(); tick();
    vsync = 1'b0; tick(); tick(); tick();
    for (int l = 0; l < nlines; l++) begin
      n = x;
      if (l == short_line) n = x - 1;
      if (rand_len) n = int'($urandom_range(x + 1, x - 1));
      href = 1'b1;
      for (int p = 0; p < n; p++) begin
        repeat ($urandom_range(0, 1)) begin regw = 1'b0; tick(); end
        if (p == n - 1 && $urandom_range(0, 1) == 1) href = 1'b0;
        a = (l == bad_line && p == 2) ? ima + 5 : acnt;
        acnt++;
        if (a < ima) exp_wr++; else exp_err = 1'b1;
        regw = 1'b1; addr = 15'(a);
        tick();
      end
      regw = 1'b0; href = 1'b0;
      if (n != x) exp_err = 1'b1;
      if (l == start_line) start = 1'b1;
      if (l == stop_line)  stop  = 1'b1;
      if (l == rst_line)   rst   = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0; rst = 1'b0;
      if (l == rst_line) snap_rst = int'({s_regw, s_busy, s_done, s_err, (s_fcnt != 16'd0)});
      if (l < 128) err_line[l] = int'(s_err);
      repeat ($urandom_range(1, 3)) tick();
    end
    if (nlines < y) exp_err = 1'b1;
    vsync = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    vsync = 1'b1; href = 1'b0; regw = 1'b0; addr = '0;
    tick(); tick();
    rst = 1'b0; regw = 1'b1;   // strobe while idle must stay gated
    tick();
    total++; if (s_regw !== 1'b0) $display("FAIL reset_regw: got %b want 0", s_regw); else passed++;
    total++; if (b_regw !== 1'b0) $display("FAIL reset_regw_big: got %b want 0", b_regw); else passed++;
    total++; if (s_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", s_busy); else passed++;
    total++; if (b_busy !== 1'b0) $display("FAIL reset_busy_big: got %b want 0", b_busy); else passed++;
    total++; if (s_done !== 1'b0) $display("FAIL reset_done: got %b want 0", s_done); else passed++;
    total++; if (s_err !== 1'b0)  $display("FAIL reset_err: got %b want 0", s_err); else passed++;
    total++; if (s_fcnt !== 16'd0) $display("FAIL reset_fcnt: got %0d want 0", s_fcnt); else passed++;
    regw = 1'b0;
  endtask

  task automatic test_single_frame();
    int ew; bit ee;
    do_reset(); continuous = 1'b0;
    pulse_start(); clear_mon();
    send_frame(BX, BY, BY, BIMA, -1, -1, -1, -1, -1, 1'b0, ew, ee);
    total++; if (wr_b !== BX * BY) $display("FAIL single_writes: got %0d want %0d", wr_b, BX * BY); else passed++;
    total++; if (fd_b !== 1) $display("FAIL single_done: got %0d want 1", fd_b); else passed++;
    total++; if (b_busy !== 1'b0) $display("FAIL single_idle: got %b want 0", b_busy); else passed++;
    total++; if (b_err !== ee) $display("FAIL single_err: got %b want %b", b_err, ee); else passed++;
  endtask

  task automatic test_continuous();
    int ew, sum; bit ee;
    do_reset(); continuous = 1'b1; sum = 0;
    pulse_start(); clear_mon();
    for (int f = 0; f < 3; f++) begin
      send_frame(SX, SY, SY, SIMA, -1, -1, -1, -1, -1, 1'b0, ew, ee);
      sum += ew;
    end
    total++; if (fd_s !== 3) $display("FAIL cont_done: got %0d want 3", fd_s); else passed++;
    total++; if (wr_s !== sum) $display("FAIL cont_writes: got %0d want %0d", wr_s, sum); else passed++;
    total++; if (gap_s !== 0) $display("FAIL cont_busy_gap: got %0d idle cycles want 0", gap_s); else passed++;
    total++; if (s_busy !== 1'b1) $display("FAIL cont_rearmed: got %b want 1", s_busy); else passed++;
    total++; if (s_fcnt !== 16'(FCNT3)) $display("FAIL cont_fcnt: got %0d want %0d", s_fcnt, FCNT3); else passed++;
    stop = 1'b1; tick(); stop = 1'b0; tick();
    total++; if (s_busy !== 1'b0) $display("FAIL cont_stop_arm: got %b want 0", s_busy); else passed++;
    continuous = 1'b0;
  endtask

  task automatic test_short_line();
    int ew; bit ee;
    do_reset(); pulse_start(); clear_mon();
    send_frame(SX, SY, SY, SIMA, 3, -1, -1, -1, -1, 1'b0, ew, ee);
    total++; if (err_line[2] !== 0) $display("FAIL short_err_before: got %0d want 0", err_line[2]); else passed++;
    total++; if (err_line[3] !== 1) $display("FAIL short_err_after: got %0d want 1", err_line[3]); else passed++;
    total++; if (fd_s !== 1) $display("FAIL short_done: got %0d want 1", fd_s); else passed++;
    total++; if (wr_s !== ew) $display("FAIL short_writes: got %0d want %0d", wr_s, ew); else passed++;
    total++; if (s_err !== ee) $display("FAIL short_err_end: got %b want %b", s_err, ee); else passed++;
    total++; if (s_busy !== 1'b0) $display("FAIL short_idle: got %b want 0", s_busy); else passed++;
    pulse_start();
    total++; if (s_err !== 1'b0) $display("FAIL short_err_clear: got %b want 0", s_err); else passed++;
  endtask

  task automatic test_start_mid_frame();
    int ew; bit ee;
    do_reset(); clear_mon();
    send_frame(SX, SY, SY, SIMA, -1, -1, 3, -1, -1, 1'b0, ew, ee);
    total++; if (wr_s !== 0) $display("FAIL mid_no_writes: got %0d want 0", wr_s); else passed++;
    total++; if (fd_s !== 0) $display("FAIL mid_no_done: got %0d want 0", fd_s); else passed++;
    total++; if (s_busy !== 1'b1) $display("FAIL mid_armed: got %b want 1", s_busy); else passed++;
    clear_mon();
    send_frame(SX, SY, SY, SIMA, -1, -1, -1, -1, -1, 1'b0, ew, ee);
    total++; if (wr_s !== ew) $display("FAIL mid_writes: got %0d want %0d", wr_s, ew); else passed++;
    total++; if (fd_s !== 1) $display("FAIL mid_done: got %0d want 1", fd_s); else passed++;
    total++; if (s_err !== ee) $display("FAIL mid_err: got %b want %b", s_err, ee); else passed++;
  endtask

  task automatic test_stop();
    int ew; bit ee;
    do_reset(); continuous = 1'b1;
    pulse_start(); clear_mon();
    send_frame(SX, SY, SY, SIMA, -1, -1, -1, SY / 2, -1, 1'b0, ew, ee);
    total++; if (fd_s !== 1) $display("FAIL stop_done: got %0d want 1", fd_s); else passed++;
    total++; if (wr_s !== ew) $display("FAIL stop_writes: got %0d want %0d", wr_s, ew); else passed++;
    total++; if (s_busy !== 1'b0) $display("FAIL stop_idle: got %b want 0", s_busy); else passed++;
    clear_mon();
    send_frame(SX, SY, SY, SIMA, -1, -1, -1, -1, -1, 1'b0, ew, ee);
    total++; if (wr_s !== 0) $display("FAIL stop_no_writes: got %0d want 0", wr_s); else passed++;
    total++; if (fd_s !== 0) $display("FAIL stop_no_done: got %0d want 0", fd_s); else passed++;
    continuous = 1'b0;
  endtask

  task automatic test_rst_mid_frame();
    int ew; bit ee;
    do_reset(); pulse_start(); clear_mon();
    snap_rst = -1;
    send_frame(SX, SY, SY, SIMA, -1, -1, -1, -1, 2, 1'b0, ew, ee);
    total++; if (snap_rst !== 0) $display("FAIL rst_outputs: got %0d want 0", snap_rst); else passed++;
    total++; if (fd_s !== 0) $display("FAIL rst_no_done: got %0d want 0", fd_s); else passed++;
    total++; if (s_busy !== 1'b0) $display("FAIL rst_idle: got %b want 0", s_busy); else passed++;
  endtask

  task automatic test_short_frame();
    int ew; bit ee;
    do_reset(); pulse_start(); clear_mon();
    send_frame(BX, BY, 100, BIMA, -1, -1, -1, -1, -1, 1'b0, ew, ee);
    total++; if (b_err !== ee) $display("FAIL sframe_err: got %b want %b", b_err, ee); else passed++;
    total++; if (fd_b !== 1) $display("FAIL sframe_done: got %0d want 1", fd_b); else passed++;
    total++; if (wr_b !== ew) $display("FAIL sframe_writes: got %0d want %0d", wr_b, ew); else passed++;
    total++; if (b_busy !== 1'b0) $display("FAIL sframe_idle: got %b want 0", b_busy); else passed++;
  endtask

  task automatic test_bad_addr();
    int ew; bit ee;
    do_reset(); pulse_start(); clear_mon();
    send_frame(SX, SY, SY, SIMA, -1, 5, -1, -1, -1, 1'b0, ew, ee);
    total++; if (wr_s !== ew) $display("FAIL badaddr_writes: got %0d want %0d", wr_s, ew); else passed++;
    total++; if (s_err !== ee) $display("FAIL badaddr_err: got %b want %b", s_err, ee); else passed++;
    total++; if (fd_s !== 1) $display("FAIL badaddr_done: got %0d want 1", fd_s); else passed++;
  endtask

  task automatic test_random_lines();
    int ew; bit ee;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      pulse_start(); clear_mon();
      send_frame(SX, SY, SY, SIMA, -1, -1, -1, -1, -1, 1'b1, ew, ee);
      total++; if (wr_s !== ew) $display("FAIL rand_writes[%0d]: got %0d want %0d", k, wr_s, ew); else passed++;
      total++; if (s_err !== ee) $display("FAIL rand_err[%0d]: got %b want %b", k, s_err, ee); else passed++;
      total++; if (fd_s !== 1) $display("FAIL rand_done[%0d]: got %0d want 1", k, fd_s); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    vsync = 1'b1; href = 1'b0; regw = 1'b0; addr = '0;
    test_reset();
    test_single_frame();
    test_continuous();
    test_short_line();
    test_start_mid_frame();
    test_stop();
    test_rst_mid_frame();
    test_short_frame();
    test_bad_addr();
    test_random_lines();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
